// File: rtl/fft_frame_ctrl.sv
// Frame controller around a streaming FFT core: gathers N samples per frame (zero-padding on
// underrun), re-registers the bit-reversed FFT output with natural-order bin tags, and watches for stalls.
module fft_frame_ctrl #(
  parameter int WIDTH = 16,
  parameter int N     = 128,
  parameter int TMO   = 255,
  localparam int LOGN = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             err_clr,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  output logic             s_ready,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic             m_sof,
  output logic             m_eof,
  output logic [LOGN-1:0]  m_bin,
  output logic [2:0]       in_flight,
  output logic             busy,
  output logic             err_underrun,
  output logic             err_timeout
);

  localparam int WDW = $clog2(TMO + 1);
  localparam logic [LOGN-1:0] LAST     = LOGN'(N - 1);
  localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TMO);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    PAD
  } state_t;

  state_t          state;
  logic [LOGN-1:0] icnt;
  logic [LOGN-1:0] ocnt;
  logic [WDW-1:0]  wd_cnt;

  logic issue_last;
  logic underrun_set;
  logic wd_clear;
  logic timeout_set;

  function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      IDLE:    s_ready = enable;
      FEED:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // In FEED and PAD a sample goes out every cycle, so icnt==N-1 marks the frame's last issue.
  assign issue_last   = (state != IDLE) && (icnt == LAST);
  assign underrun_set = (state == FEED) && !s_valid;
  assign busy         = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      icnt      <= '0;
      fft_di_en <= 1'b0;
      fft_di_re <= '0;
      fft_di_im <= '0;
    end else begin
      fft_di_en <= 1'b0;
      fft_di_re <= '0;
      fft_di_im <= '0;
      unique case (state)
        IDLE: begin
          if (s_valid && enable) begin
            fft_di_en <= 1'b1;
            fft_di_re <= s_re;
            fft_di_im <= s_im;
            icnt      <= LOGN'(1);
            state     <= FEED;
          end
        end
        FEED: begin
          fft_di_en <= 1'b1;
          icnt      <= icnt + LOGN'(1);
          if (s_valid) begin
            fft_di_re <= s_re;
            fft_di_im <= s_im;
          end
          if (icnt == LAST)  state <= IDLE;
          else if (!s_valid) state <= PAD;
        end
        PAD: begin
          fft_di_en <= 1'b1;
          icnt      <= icnt + LOGN'(1);
          if (icnt == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ocnt    <= '0;
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      m_bin   <= '0;
    end else begin
      m_valid <= fft_do_en;
      m_re    <= fft_do_en ? fft_do_re : '0;
      m_im    <= fft_do_en ? fft_do_im : '0;
      m_sof   <= fft_do_en && (ocnt == '0);
      m_eof   <= fft_do_en && (ocnt == LAST);
      m_bin   <= fft_do_en ? bit_rev(ocnt) : '0;
      if (fft_do_en) ocnt <= ocnt + LOGN'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      unique case ({issue_last, m_eof})
        2'b10:   if (in_flight != 3'd7) in_flight <= in_flight + 3'd1;
        2'b01:   if (in_flight != 3'd0) in_flight <= in_flight - 3'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // The flag is set only on the step that reaches the limit, so err_clr sticks while the counter holds.
  assign wd_clear    = fft_do_en || (in_flight == 3'd0);
  assign timeout_set = !wd_clear && (wd_cnt == WD_LIMIT - WDW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      err_underrun <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (wd_clear)                wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + WDW'(1);

      if (underrun_set) err_underrun <= 1'b1;
      else if (err_clr) err_underrun <= 1'b0;

      if (timeout_set)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: short cycle table for the input FSM plus hand-written
// sequences for full frames, underrun, back-to-back, output tagging, timeout and mid-frame reset.
module tb_fft_frame_ctrl;
  localparam int WIDTH = 16;
  localparam int N     = 128;
  localparam int TMO   = 255;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             err_clr;
  logic             s_valid;
  logic [WIDTH-1:0] s_re;
  logic [WIDTH-1:0] s_im;
  logic             s_ready;
  logic             fft_di_en;
  logic [WIDTH-1:0] fft_di_re;
  logic [WIDTH-1:0] fft_di_im;
  logic             fft_do_en;
  logic [WIDTH-1:0] fft_do_re;
  logic [WIDTH-1:0] fft_do_im;
  logic             m_valid;
  logic [WIDTH-1:0] m_re;
  logic [WIDTH-1:0] m_im;
  logic             m_sof;
  logic             m_eof;
  logic [6:0]       m_bin;
  logic [2:0]       in_flight;
  logic             busy;
  logic             err_underrun;
  logic             err_timeout;

  fft_frame_ctrl #(.WIDTH(WIDTH), .N(N), .TMO(TMO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .err_clr(err_clr),
    .s_valid(s_valid), .s_re(s_re), .s_im(s_im), .s_ready(s_ready),
    .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_sof(m_sof), .m_eof(m_eof),
    .m_bin(m_bin), .in_flight(in_flight), .busy(busy),
    .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] re;
    logic [15:0] im;
    logic        exp_ready;
    logic        exp_di_en;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
    logic        exp_busy;
    logic        exp_under;
  } vec_t;

  vec_t vecs[6];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rev7(input int k);
    int r;
    int x;
    r = 0;
    x = k;
    for (int i = 0; i < 7; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0; err_clr = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
    fft_do_en = 1'b0; fft_do_re = '0; fft_do_im = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Streams total cycles of input; within each frame the first n_valid samples are valid.
  task automatic run_samples(input int total, input int n_valid, input int base, input string tag);
    for (int k = 0; k < total; k++) begin
      int fk;
      logic v;
      logic [15:0] er;
      logic [15:0] ei;
      fk = k % N;
      v = (fk < n_valid);
      enable = 1'b1;
      s_valid = v;
      s_re = 16'(base + k);
      s_im = ~16'(base + k);
      er = v ? s_re : 16'h0;
      ei = v ? s_im : 16'h0;
      #1 check({tag, " s_ready"}, 32'(s_ready), 32'(fk <= n_valid));
      tick();
      check({tag, " di_en"}, 32'(fft_di_en), 32'd1);
      check({tag, " di_re"}, 32'(fft_di_re), 32'(er));
      check({tag, " di_im"}, 32'(fft_di_im), 32'(ei));
    end
    s_valid = 1'b0;
    s_re = '0;
    s_im = '0;
  endtask

  task automatic run_output(input int base, input string tag);
    for (int k = 0; k < N; k++) begin
      fft_do_en = 1'b1;
      fft_do_re = 16'(base + k);
      fft_do_im = 16'(k * 3);
      tick();
      check({tag, " m_valid"}, 32'(m_valid), 32'd1);
      check({tag, " m_re"}, 32'(m_re), 32'(16'(base + k)));
      check({tag, " m_im"}, 32'(m_im), 32'(16'(k * 3)));
      check({tag, " m_sof"}, 32'(m_sof), 32'(k == 0));
      check({tag, " m_eof"}, 32'(m_eof), 32'(k == N - 1));
      check({tag, " m_bin"}, 32'(m_bin), 32'(rev7(k)));
    end
    fft_do_en = 1'b0;
    fft_do_re = '0;
    fft_do_im = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit: run did not complete");
    $fatal(1);
  end

  initial begin
    //         en    vld   re      im        rdy   di_en exp_re  exp_im    busy  under
    vecs[0] = '{1'b0, 1'b1, 16'd5,  16'd6,    1'b0, 1'b0, 16'd0,  16'd0,    1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'd7,  16'd8,    1'b1, 1'b0, 16'd0,  16'd0,    1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'd11, 16'hFFFD, 1'b1, 1'b1, 16'd11, 16'hFFFD, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'd12, 16'd7,    1'b1, 1'b1, 16'd12, 16'd7,    1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'd33, 16'd44,   1'b1, 1'b1, 16'd0,  16'd0,    1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'd99, 16'd1,    1'b0, 1'b1, 16'd0,  16'd0,    1'b1, 1'b1};

    // Reset state, with s_ready following enable while reset is held
    reset = 1'b1;
    enable = 1'b0; err_clr = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
    fft_do_en = 1'b0; fft_do_re = '0; fft_do_im = '0;
    @(negedge clock);
    check("rst di_en", 32'(fft_di_en), 32'd0);
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_bin", 32'(m_bin), 32'd0);
    check("rst in_flight", 32'(in_flight), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst errors", 32'({err_underrun, err_timeout}), 32'd0);
    check("rst s_ready en0", 32'(s_ready), 32'd0);
    enable = 1'b1;
    #1 check("rst s_ready en1", 32'(s_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;

    // Cycle table: idle gating, frame start, enable drop mid-frame, underrun into PAD
    for (int i = 0; i < 6; i++) begin
      enable = vecs[i].en;
      s_valid = vecs[i].vld;
      s_re = vecs[i].re;
      s_im = vecs[i].im;
      #1 check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("vec%0d di_en", i), 32'(fft_di_en), 32'(vecs[i].exp_di_en));
      check($sformatf("vec%0d di_re", i), 32'(fft_di_re), 32'(vecs[i].exp_re));
      check($sformatf("vec%0d di_im", i), 32'(fft_di_im), 32'(vecs[i].exp_im));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d underrun", i), 32'(err_underrun), 32'(vecs[i].exp_under));
    end
    // Four samples issued so far; padding must complete the remaining 124
    s_valid = 1'b0;
    enable = 1'b0;
    for (int k = 4; k < N; k++) begin
      tick();
      check("pad di_en", 32'(fft_di_en), 32'd1);
      check("pad di_re", 32'(fft_di_re), 32'd0);
    end
    check("pad in_flight", 32'(in_flight), 32'd1);
    check("pad busy end", 32'(busy), 32'd0);
    tick();
    check("pad di_en off", 32'(fft_di_en), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr underrun", 32'(err_underrun), 32'd0);

    // Continuous frame
    do_reset();
    run_samples(N, N, 0, "cont");
    check("cont in_flight", 32'(in_flight), 32'd1);
    check("cont busy", 32'(busy), 32'd0);
    check("cont underrun", 32'(err_underrun), 32'd0);
    tick();
    check("cont di_en off", 32'(fft_di_en), 32'd0);

    // Underrun at sample 50
    do_reset();
    run_samples(N, 50, 0, "undr");
    check("undr flag", 32'(err_underrun), 32'd1);
    check("undr in_flight", 32'(in_flight), 32'd1);
    tick();
    check("undr di_en off", 32'(fft_di_en), 32'd0);

    // Back-to-back frames, then two output frames draining in_flight
    do_reset();
    run_samples(2 * N, N, 0, "b2b");
    check("b2b in_flight", 32'(in_flight), 32'd2);
    run_output(1000, "out0");
    check("out0 in_flight at eof", 32'(in_flight), 32'd2);
    tick();
    check("out0 m_valid off", 32'(m_valid), 32'd0);
    check("out0 in_flight dec", 32'(in_flight), 32'd1);
    run_output(3000, "out1");
    tick();
    check("out1 in_flight dec", 32'(in_flight), 32'd0);

    // Watchdog timeout with no FFT output
    do_reset();
    run_samples(N, N, 0, "tmo");
    check("tmo in_flight", 32'(in_flight), 32'd1);
    repeat (TMO - 1) tick();
    check("tmo before limit", 32'(err_timeout), 32'd0);
    tick();
    check("tmo at limit", 32'(err_timeout), 32'd1);
    repeat (3) tick();
    check("tmo sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo cleared", 32'(err_timeout), 32'd0);
    repeat (3) tick();
    check("tmo stays clear", 32'(err_timeout), 32'd0);

    // Reset at sample 60, then a clean frame
    do_reset();
    run_samples(60, N, 0, "pre");
    s_valid = 1'b1;
    enable = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst di_en", 32'(fft_di_en), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst in_flight", 32'(in_flight), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_samples(N, N, 500, "post");
    check("post in_flight", 32'(in_flight), 32'd1);
    check("post busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width per real/imag component.
REQ-002 SHALL have parameter N, default 128: FFT frame length in samples, power of two.
REQ-003 SHALL have parameter TMO, default 255: watchdog limit in cycles.
REQ-004 SHALL have ports:
  - clock  in  1  master clock, all logic on rising edge
  - reset  in  1  asynchronous, active-high reset
  - enable  in  1  permits acceptance of a new frame
  - err_clr  in  1  clears sticky error flags
  - s_valid  in  1  upstream sample valid
  - s_re, s_im  in  WIDTH  upstream sample
  - s_ready  out  1  upstream sample accepted this cycle when high with s_valid
  - fft_di_en, fft_di_re, fft_di_im  out  1/WIDTH/WIDTH  registered drive to FFT input
  - fft_do_en, fft_do_re, fft_do_im  in  1/WIDTH/WIDTH  FFT output, bit-reversed order
  - m_valid, m_re, m_im  out  1/WIDTH/WIDTH  registered FFT output
  - m_sof, m_eof  out  1  first / last sample of output frame
  - m_bin  out  log2(N)  natural-order bin index of m_re/m_im
  - in_flight  out  3  frames fully issued but not yet fully output
  - busy  out  1  state not IDLE
  - err_underrun, err_timeout  out  1  sticky error flags

Function
REQ-005 Input FSM SHALL have states IDLE, FEED, PAD; icnt (log2(N) bits) counts issued samples of the current frame.
REQ-006 s_ready SHALL be combinational: enable in IDLE, 1 in FEED, 0 in PAD.
REQ-007 IDLE: s_valid & enable -> issue sample 0 from s_re/s_im, icnt=1, go FEED; otherwise fft_di_en=0 next cycle.
REQ-008 FEED: s_valid -> issue s_re/s_im; if icnt==N-1, go IDLE, else icnt++.
REQ-009 FEED with s_valid=0 -> issue zero sample, set err_underrun, go PAD (or IDLE if icnt==N-1).
REQ-010 PAD: issue zero sample every cycle, icnt++; at icnt==N-1 go IDLE.
REQ-011 "Issue" SHALL mean fft_di_en=1 and fft_di_re/im=sample on the next clock edge (1-cycle latency); fft_di_en is otherwise 0 and data 0.
REQ-012 Once a frame starts, fft_di_en SHALL be high exactly N consecutive cycles; back-to-back frames SHALL produce no bubble (IDLE accepts in the same cycle it is entered).
REQ-013 Output path SHALL register fft_do_* into m_valid/m_re/m_im with 1-cycle latency; ocnt counts fft_do_en cycles modulo N.
REQ-014 m_sof SHALL be 1 with m_valid when ocnt==0; m_eof SHALL be 1 when ocnt==N-1; m_bin SHALL equal bit-reverse of ocnt.
REQ-015 in_flight SHALL +1 on issue of sample N-1 and -1 on m_eof; simultaneous events leave it unchanged; saturate at 7 and 0.
REQ-016 Watchdog counter SHALL clear on fft_do_en or when in_flight==0, else increment; reaching TMO sets err_timeout and the counter holds.
REQ-017 err_clr SHALL clear both error flags; a set event in the same cycle wins.
REQ-018 enable deassertion SHALL NOT abort a frame in progress; it only blocks the next IDLE acceptance.

Reset
REQ-019 reset SHALL asynchronously force state IDLE, icnt=ocnt=watchdog=0, and all outputs 0 (s_ready then follows enable).
REQ-020 Reset mid-frame SHALL drop the partial frame without padding; fft_di_en=0 from reset assertion.

Verification
REQ-021 Continuous frame: enable=1, s_valid=1 for 128 cycles, s_re=k -> fft_di_en high cycles 1..128, fft_di_re=0..127, in_flight=1 after last.
REQ-022 Underrun: s_valid drops at sample 50 -> samples 50..127 are 0, fft_di_en still 128 cycles, err_underrun=1, s_ready=0 through sample 127.
REQ-023 Back-to-back: s_valid=1 for 256 cycles -> fft_di_en high 256 consecutive cycles, in_flight=2.
REQ-024 Output: fft_do_en high 128 cycles -> m_sof on first, m_eof on 128th, m_bin=0,64,32,96,16,..., in_flight decrements.
REQ-025 Timeout: one frame issued, fft_do_en held 0 -> err_timeout=1 after 255 cycles; err_clr pulse -> 0.
REQ-026 Reset at sample 60 -> fft_di_en=0 immediately, busy=0, in_flight=0; next frame starts at icnt=0.
